// File: rtl/sram_arbiter_if.sv
// Requester-side command/response bundle for sram_arbiter: two ports, each with
// a request/grant command handshake and a read-data valid pulse.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req_0;
    logic              we_0;
    logic [ADDR_W-1:0] addr_0;
    logic [DATA_W-1:0] wdata_0;
    logic [1:0]        be_0;
    logic              gnt_0;
    logic              rvalid_0;
    logic [DATA_W-1:0] rdata_0;

    logic              req_1;
    logic              we_1;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_1;
    logic [1:0]        be_1;
    logic              gnt_1;
    logic              rvalid_1;
    logic [DATA_W-1:0] rdata_1;

    modport master (
        output req_0, we_0, addr_0, wdata_0, be_0,
        output req_1, we_1, addr_1, wdata_1, be_1,
        input  gnt_0, rvalid_0, rdata_0,
        input  gnt_1, rvalid_1, rdata_1
    );

    modport slave (
        input  req_0, we_0, addr_0, wdata_0, be_0,
        input  req_1, we_1, addr_1, wdata_1, be_1,
        output gnt_0, rvalid_0, rdata_0,
        output gnt_1, rvalid_1, rdata_1
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter sequencing the async board SRAM (SETUP/STROBE/TURN); SRAM_ARB_AUDIO_PRIO_EN gives port 0 strict priority.
// Latency: gnt in the IDLE cycle, rvalid 2+STROBE_CYCLES cycles later; one access per 3+STROBE_CYCLES cycles.
// Backpressure: req is held until the single-cycle gnt; a busy arbiter simply withholds gnt.
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              res_n,
    sram_arbiter_if.slave     bus,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, TURN} state_t;

    localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic              port_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;
    logic [DATA_W-1:0] rdata_0_q, rdata_1_q;

    logic any_req, win_1, take, capture, dq_oe;
    logic gnt_0_c, gnt_1_c, rvalid_0_c, rvalid_1_c;

    assign any_req = bus.req_0 | bus.req_1;

`ifdef SRAM_ARB_AUDIO_PRIO_EN
    assign win_1 = ~bus.req_0;
`else
    // On a conflict the port that did not win last time goes next.
    assign win_1 = bus.req_1 & (~bus.req_0 | ~last_grant_q);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        take       = 1'b0;
        capture    = 1'b0;
        dq_oe      = 1'b0;
        gnt_0_c    = 1'b0;
        gnt_1_c    = 1'b0;
        rvalid_0_c = 1'b0;
        rvalid_1_c = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_ub_n  = 1'b1;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    take    = 1'b1;
                    gnt_0_c = ~win_1;
                    gnt_1_c = win_1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                sram_ce_n = 1'b0;
                sram_lb_n = ~be_q[0];
                sram_ub_n = ~be_q[1];
                dq_oe     = we_q;
                cnt_d     = CNT_INIT;
                state_d   = STROBE;
            end
            STROBE: begin
                sram_ce_n = 1'b0;
                sram_lb_n = ~be_q[0];
                sram_ub_n = ~be_q[1];
                sram_oe_n = we_q;
                sram_we_n = ~we_q;
                dq_oe     = we_q;
                if (cnt_q == 4'd0) begin
                    capture = ~we_q;
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TURN: begin
                // dq already released here, so a following read cannot collide.
                rvalid_0_c = ~we_q & ~port_q;
                rvalid_1_c = ~we_q & port_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 2'b00;
            rdata_0_q    <= '0;
            rdata_1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                we_q         <= win_1 ? bus.we_1    : bus.we_0;
                addr_q       <= win_1 ? bus.addr_1  : bus.addr_0;
                wdata_q      <= win_1 ? bus.wdata_1 : bus.wdata_0;
                be_q         <= win_1 ? bus.be_1    : bus.be_0;
                port_q       <= win_1;
                last_grant_q <= win_1;
            end
            if (capture) begin
                if (port_q) rdata_1_q <= sram_dq;
                else        rdata_0_q <= sram_dq;
            end
        end
    end

    assign sram_dq      = dq_oe ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr    = addr_q;
    assign bus.gnt_0    = gnt_0_c;
    assign bus.gnt_1    = gnt_1_c;
    assign bus.rvalid_0 = rvalid_0_c;
    assign bus.rvalid_1 = rvalid_1_c;
    assign bus.rdata_0  = rdata_0_q;
    assign bus.rdata_1  = rdata_1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed and randomized accesses against a behavioural
// SRAM device plus a reference memory and grant-order model.
module tb_sram_arbiter;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int S      = 2;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wire  [DATA_W-1:0] sram_dq;
    logic [ADDR_W-1:0] sram_addr;
    logic sram_lb_n, sram_ub_n, sram_ce_n, sram_oe_n, sram_we_n;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYCLES(S)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .bus       (bus),
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_lb_n (sram_lb_n),
        .sram_ub_n (sram_ub_n),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    // Board SRAM: 256 words decoded from the low address byte.
    logic [15:0] dev_mem [0:255];
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr[7:0]] : 16'hzzzz;
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) dev_mem[sram_addr[7:0]][7:0]  = sram_dq[7:0];
            if (!sram_ub_n) dev_mem[sram_addr[7:0]][15:8] = sram_dq[15:8];
        end
    end

    int contention = 0;
    always @(negedge clk) if (dut.dq_oe && !sram_oe_n) contention++;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem [0:255];
    logic        model_last;
    bit          got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_winner(input logic r0, input logic r1, input logic last);
`ifdef SRAM_ARB_AUDIO_PRIO_EN
        return r0 ? 1'b0 : 1'b1;
`else
        if (r0 && r1) return ~last;
        return r0 ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic drive_port(input logic p, input logic r, input logic we,
                              input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        if (!p) begin
            bus.req_0 = r; bus.we_0 = we; bus.addr_0 = a; bus.wdata_0 = d; bus.be_0 = be;
        end else begin
            bus.req_1 = r; bus.we_1 = we; bus.addr_1 = a; bus.wdata_1 = d; bus.be_1 = be;
        end
    endtask

    function automatic logic gnt_of(input logic p);
        return p ? bus.gnt_1 : bus.gnt_0;
    endfunction
    function automatic logic rvalid_of(input logic p);
        return p ? bus.rvalid_1 : bus.rvalid_0;
    endfunction
    function automatic logic [15:0] rdata_of(input logic p);
        return p ? bus.rdata_1 : bus.rdata_0;
    endfunction

    // One single-requester access, checking every pin cycle by cycle.
    task automatic access(input logic p, input logic we, input logic [19:0] a,
                          input logic [15:0] d, input logic [1:0] be);
        logic [15:0] other_rd;
        bit ok = 0;
        bit strobe, turn;
        @(posedge clk); #1;
        drive_port(p, 1'b1, we, a, d, be);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (gnt_of(p)) ok = 1;
        end
        chk("gnt_seen", 32'(ok), 1);
        if (!ok) begin
            drive_port(p, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
            return;
        end
        chk("gnt_other_low", 32'(gnt_of(~p)), 0);
        model_last = p;
        @(posedge clk); #1;
        drive_port(p, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
        if (we) begin
            if (be[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
            if (be[1]) ref_mem[a[7:0]][15:8] = d[15:8];
        end
        other_rd = rdata_of(~p);
        for (int k = 1; k <= 2 + S; k++) begin
            @(negedge clk);
            strobe = (k >= 2) && (k <= 1 + S);
            turn   = (k == 2 + S);
            chk("ce_n",  32'(sram_ce_n), 32'(turn));
            chk("oe_n",  32'(sram_oe_n), 32'(!(strobe && !we)));
            chk("we_n",  32'(sram_we_n), 32'(!(strobe && we)));
            chk("dq_drive", 32'(dut.dq_oe), 32'(we && !turn));
            if (!turn) begin
                chk("lb_n", 32'(sram_lb_n), 32'(!be[0]));
                chk("ub_n", 32'(sram_ub_n), 32'(!be[1]));
                chk("addr", 32'(sram_addr), 32'(a));
                if (we) chk("dq_wdata", 32'(sram_dq), 32'(d));
            end
            chk("rvalid_own",   32'(rvalid_of(p)),  32'(turn && !we));
            chk("rvalid_other", 32'(rvalid_of(~p)), 0);
        end
        if (!we && be == 2'b11) chk("rdata", 32'(rdata_of(p)), 32'(ref_mem[a[7:0]]));
        chk("rdata_other_hold", 32'(rdata_of(~p)), 32'(other_rd));
    endtask

    // Both ports request continuously until n_acc grants, checking order and spacing.
    task automatic both_requesting(input int n_acc);
        int n = 0, last_t = -1, rv_cyc = -1;
        logic rv_port = 1'b0, w;
        logic [15:0] snap0, snap1;
        snap0 = bus.rdata_0;
        snap1 = bus.rdata_1;
        @(posedge clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0, 2'b11);
        drive_port(1'b1, 1'b1, 1'b0, 20'hABCDE, 16'h0, 2'b11);
        for (int c = 0; c < 10 * n_acc; c++) begin
            @(negedge clk);
            chk("rr_rvalid0", 32'(bus.rvalid_0), 32'(cyc == rv_cyc && rv_port == 1'b0));
            chk("rr_rvalid1", 32'(bus.rvalid_1), 32'(cyc == rv_cyc && rv_port == 1'b1));
            if (cyc == rv_cyc) begin
                if (rv_port) begin
                    chk("rr_rdata1", 32'(bus.rdata_1), 32'(ref_mem[8'hDE]));
                    chk("rr_rdata0_hold", 32'(bus.rdata_0), 32'(snap0));
                    snap1 = bus.rdata_1;
                end else begin
                    chk("rr_rdata0", 32'(bus.rdata_0), 32'(ref_mem[8'h10]));
                    chk("rr_rdata1_hold", 32'(bus.rdata_1), 32'(snap1));
                    snap0 = bus.rdata_0;
                end
                if (n == n_acc) break;
            end
            if (bus.gnt_0 || bus.gnt_1) begin
                w = bus.gnt_1;
                chk("rr_single_gnt", 32'(bus.gnt_0 & bus.gnt_1), 0);
                chk("rr_winner", 32'(w), 32'(exp_winner(1'b1, 1'b1, model_last)));
                if (last_t >= 0) chk("rr_spacing", 32'(cyc - last_t), 32'(3 + S));
                last_t = cyc;
                model_last = w;
                rv_port = w;
                rv_cyc = cyc + 2 + S;
                n++;
                if (n == n_acc) begin
                    @(posedge clk); #1;
                    drive_port(1'b0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
                    drive_port(1'b1, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
                end
            end
        end
        chk("rr_grant_count", 32'(n), 32'(n_acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] pool [0:5];
        logic [15:0] old;
        drive_port(1'b0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
        drive_port(1'b1, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
        model_last = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 16'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[8'h10] = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;
        for (int i = 0; i < 6; i++) pool[i] = {12'($urandom), 8'(8'h20 + 8'(i * 7))};

        #12;
        chk("rst_gnt0",   32'(bus.gnt_0), 0);
        chk("rst_gnt1",   32'(bus.gnt_1), 0);
        chk("rst_rvalid", 32'({bus.rvalid_0, bus.rvalid_1}), 0);
        chk("rst_rdata0", 32'(bus.rdata_0), 0);
        chk("rst_rdata1", 32'(bus.rdata_1), 0);
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
        chk("rst_addr",   32'(sram_addr), 0);
        chk("rst_dq_z",   32'(dut.dq_oe), 0);
        res_n = 1'b1;

        // Port 0 read of 0xBEEF.
        access(1'b0, 1'b0, 20'h00010, 16'h0, 2'b11);
        chk("rd_beef", 32'(bus.rdata_0), 32'h0000BEEF);

        // Port 1 upper-byte write.
        old = dev_mem[8'hDE];
        access(1'b1, 1'b1, 20'hABCDE, 16'h1234, 2'b10);
        chk("wr_upper_only", 32'(dev_mem[8'hDE]), 32'({8'h12, old[7:0]}));

        // Write then immediate read on port 0.
        access(1'b0, 1'b1, 20'h00033, 16'h5A5A, 2'b11);
        access(1'b0, 1'b0, 20'h00033, 16'h0, 2'b11);

        // be=00 write leaves memory untouched.
        old = dev_mem[8'h44];
        access(1'b1, 1'b1, 20'h00044, 16'hFFFF, 2'b00);
        chk("wr_be00", 32'(dev_mem[8'h44]), 32'(old));

        both_requesting(4);

        // Reset during the STROBE of a read.
        @(posedge clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0, 2'b11);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.gnt_0) got = 1;
        end
        chk("rst_mid_gnt", 32'(got), 1);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
        @(posedge clk); #2;
        chk("rst_mid_pre_oe", 32'(sram_oe_n), 0);
        res_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        chk("rst_mid_dq_z", 32'(dut.dq_oe), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rvalid", 32'(bus.rvalid_0), 0);
            chk("rst_mid_rdata0", 32'(bus.rdata_0), 0);
        end
        #2 res_n = 1'b1;
        model_last = 1'b1;
        access(1'b0, 1'b0, 20'h00010, 16'h0, 2'b11);

        // Randomized single-requester traffic over a small address pool.
        for (int i = 0; i < 24; i++) begin
            logic p, w;
            logic [1:0] be;
            p  = 1'($urandom);
            w  = 1'($urandom);
            be = w ? 2'($urandom) : 2'b11;
            access(p, w, pool[$urandom_range(0, 5)], 16'($urandom), be);
        end

        both_requesting(6);

        chk("no_contention", 32'(contention), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 16-bit asynchronous board SRAM between two requesters: port 0 (audio sample ring buffer) and port 1 (FFT wrapper partition/spectrum storage).
- Arbitrates between the ports, sequences the SRAM pins with fixed setup/strobe/turnaround timing, and returns read data with a valid pulse.
- Sits between the reverb datapath masters and the sram_* top-level pins.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
STROBE_CYCLES, 2, cycles OE_N/WE_N held low (1..15)

Ports:
clk  in  1  system clock
res_n  in  1  async active-low reset
req_0  in  1  port 0 request; command fields held stable until gnt_0
we_0  in  1  port 0: 1=write, 0=read
addr_0  in  ADDR_W  port 0 word address
wdata_0  in  DATA_W  port 0 write data
be_0  in  2  port 0 byte enables ([1]=upper, [0]=lower)
gnt_0  out  1  port 0 command accepted (1-cycle pulse)
rvalid_0  out  1  port 0 read data valid (1-cycle pulse)
rdata_0  out  DATA_W  port 0 read data
req_1, we_1, addr_1, wdata_1, be_1, gnt_1, rvalid_1, rdata_1  same as port 0, for port 1
sram_dq  inout  DATA_W  SRAM data bus
sram_addr  out  ADDR_W  SRAM address
sram_lb_n  out  1  lower byte enable
sram_ub_n  out  1  upper byte enable
sram_ce_n  out  1  chip enable
sram_oe_n  out  1  output enable
sram_we_n  out  1  write enable

Behaviour:
- Clocking/reset: one clock `clk`; reset `res_n` is asynchronous and active-low.
- Reset values: gnt_*=0, rvalid_*=0, rdata_*=0, sram_ce_n/oe_n/we_n/lb_n/ub_n=1, sram_addr=0, sram_dq=Z, state=IDLE, last_grant=1 (so port 0 wins the first conflict).
- FSM: IDLE -> SETUP -> STROBE -> TURN -> IDLE.
- IDLE: if any req is high, select a winner, pulse its gnt for this cycle, and latch we/addr/wdata/be/port. Go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): sram_addr=latched addr, ce_n=0, lb_n=~be[0], ub_n=~be[1]. oe_n and we_n stay 1. On a write, dq is driven with wdata.
- STROBE (STROBE_CYCLES cycles, down-counter): read drives oe_n=0; write drives we_n=0 with dq driven. On a read, rdata of the owning port is registered from sram_dq on the last STROBE cycle.
- TURN (1 cycle): ce_n/oe_n/we_n=1, dq=Z. The owning port's rvalid pulses in this cycle if the access was a read. Then go to IDLE.
- Access occupancy is 3+STROBE_CYCLES cycles, IDLE included. Read latency from gnt to rvalid is 2+STROBE_CYCLES cycles.
- dq is driven only in SETUP/STROBE of a write. It is never driven during a read or in TURN, which guarantees bus turnaround.
- Arbitration is round-robin. With a single requester, that requester wins. When both request, the port != last_grant wins. last_grant updates on every grant.
- Each port's rdata holds its value until that port's next rvalid.
- A requester must keep req high until it sees gnt. Dropping req before gnt is legal and cancels the request. Changing command fields while req is high and gnt has not yet been seen is undefined.
- be=2'b00 still runs a full cycle with lb_n=ub_n=1. The read returns undefined data; the write changes no memory.
- Reset mid-access: all strobes go to 1 and dq to Z immediately (asynchronously). The in-flight access is dropped with no rvalid.

Optional Feature:
- SRAM_ARB_AUDIO_PRIO_EN defined: port 0 has strict priority. It wins every conflict and last_grant is ignored. Audio samples are never delayed by more than one in-flight access.
- Not defined: round-robin as described above.

Test Plan:
- Port 0 read at 0x00010, STROBE_CYCLES=2, model returns 0xBEEF: gnt_0 at cycle T; oe_n low at T+2..T+3; rvalid_0 and rdata_0=0xBEEF at T+4; dq never driven.
- Port 1 write of 0x1234 to 0xABCDE with be=2'b10: ub_n=0, lb_n=1, we_n low for exactly 2 cycles; dq=0x1234 from SETUP through STROBE; model upper byte=0x12, lower byte unchanged.
- req_0 and req_1 held high continuously for 4 accesses: grants go 0,1,0,1, spaced 5 cycles apart. rvalid goes to the matching port and the other port's rdata is unchanged.
- Write followed immediately by a read on port 0: dq is Z in TURN before oe_n falls, so there is no bus contention cycle.
- res_n asserted during STROBE of a read: we_n/oe_n/ce_n go to 1 and dq to Z asynchronously; no rvalid; after release the next req_0 is granted normally.
- With SRAM_ARB_AUDIO_PRIO_EN defined and both ports requesting continuously: gnt_0 on every access and port 1 starved. Without the macro, the same stimulus alternates grants.
